spi_mem_slave: RTL and testbench
================================

Name: spi_mem_slave

Overview:
- SPI mode-0 slave in front of a 32 x 8 register memory. It is the responder to the SPI master tasks used in our memory benches.
- Frame format, MSB first: 3-bit instruction, 5-bit address, then data bytes.
- sclk, cs and mosi are oversampled in the system clk domain. All state is synchronous to clk.

Parameters:
- DEPTH, 32, number of memory bytes (address width = 5, fixed by the frame format).
- DATA_W, 8, memory word and data-phase width.
- SYNC_STAGES, 2, synchronizer flops on cs, sclk and mosi.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, synchronous and active-low.
- cs  in  1  chip select, active-low.
- sclk  in  1  serial clock from master; idles low.
- mosi  in  1  master-out serial data.
- miso  out  1  slave-out serial data.
- busy  out  1  high while a frame is active (state != IDLE).
- err_pulse  out  1  one-clk pulse when an invalid instruction is decoded.

Behaviour:
- Reset (rst_n=0 at posedge clk): all memory bytes = 0x00, miso=0, busy=0, err_pulse=0, state=IDLE, counters and shift registers cleared. Reset mid-frame aborts the frame with no memory write. The slave resumes only on a fresh cs falling edge.
- Sampling:
  - cs, sclk and mosi each pass through SYNC_STAGES flops; one extra sclk flop provides edge detect.
  - Rise/fall events are single-clk strobes, 3 clk after the pin edge.
  - Legal sclk high and low phases are each >= 4 clk.
- Mode 0: mosi is sampled on sclk rise events; miso is updated on sclk fall events.
- Instructions:
  - 001 = single write.
  - 010 = single read.
  - 011 = burst write.
  - 100 = burst read.
  - All others are invalid.
- States: IDLE, HDR, WR, RD, IGNORE.
  - IDLE -> HDR on synced cs low. Bit counter is set to 0.
  - HDR: shift 8 bits. On the 8th rise, latch instr[2:0] and addr[4:0], then branch:
    - write opcodes -> WR.
    - read opcodes -> RD, and load rd_shift <= mem[addr] in the same clk.
    - invalid -> IGNORE, with err_pulse for 1 clk.
  - WR:
    - Shift 8 bits. On the 8th rise, mem[addr] <= byte on the next clk edge.
    - Single write: go to IGNORE.
    - Burst write: addr+1 and stay in WR.
  - RD:
    - The first data bit drives miso on the fall event following the 8th header rise; each later fall shifts rd_shift left.
    - After 8 falls, single read goes to IGNORE.
    - Burst read increments addr and loads the next byte on the 8th fall, so its MSB is on miso immediately.
  - IGNORE: discard all sclk activity until cs deassert.
  - Any state -> IDLE one clk after synced cs high. The partial byte is discarded, with no memory write. miso returns to 0 and busy drops.
- Address boundary: no wrap-around.
  - Once a burst has completed address 0x1F, further write bytes are ignored.
  - Further read bytes drive miso=0.
  - Addresses are 5-bit, so no overflow state exists.
- miso outside RD: 0.
- A cs deassert and an sclk edge in the same clk: cs wins and the edge is ignored.
- Write to address A, then read of A in a later frame: returns the new data.

Decomposition:
- Package spi_mem_pkg:
  - instr_e enum (INS_WR=3'b001, INS_RD=3'b010, INS_BWR=3'b011, INS_BRD=3'b100).
  - state_e enum (IDLE, HDR, WR, RD, IGNORE).
  - constants ADDR_W=5, DATA_W=8, MAX_ADDR=5'h1F.
- Sub-module spi_sync_edge: parameterized synchronizer for cs, sclk and mosi. It outputs synced levels plus sclk_rise and sclk_fall strobes.

Test Plan:
- Single write, then single read at 0x01: frame 0x21 + 0x01, cs high, then frame 0x41 -> miso shifts 0x01 MSB first, and err_pulse is never asserted.
- Burst write from 0x10 with A1,B2,C3,D4, then burst read 0x90 for 4 bytes -> returns A1,B2,C3,D4; mem[0x14] stays 0x00.
- Burst write at 0x1E with 11,22,33 -> mem[0x1E]=11, mem[0x1F]=22, 33 discarded; burst read 0x9E for 3 bytes -> 11,22,00.
- Invalid header 0xE5 followed by 8 sclk -> err_pulse for 1 clk, state IGNORE, no memory change, miso=0; the next valid frame works normally.
- Write frame 0x23 with data 0xFF, cs raised after 4 data bits -> mem[0x03] stays 0x00, busy=0 within 4 clk of the cs rise.
- rst_n low for 1 clk mid burst write -> all memory 0x00, miso=0, busy=0; later sclk with cs still low causes no writes until cs is cycled.

Source files
------------

// File: rtl/spi_mem_pkg.sv
// Shared types and constants for the SPI memory slave.
//   instr_e : 3-bit opcode carried in the top of the header byte
//   state_e : frame FSM states
package spi_mem_pkg;

  localparam int          ADDR_W   = 5;
  localparam int          DATA_W   = 8;
  localparam logic [4:0]  MAX_ADDR = 5'h1F;

  typedef enum logic [2:0] {
    INS_WR  = 3'b001,
    INS_RD  = 3'b010,
    INS_BWR = 3'b011,
    INS_BRD = 3'b100
  } instr_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HDR    = 3'd1,
    WR     = 3'd2,
    RD     = 3'd3,
    IGNORE = 3'd4
  } state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Synchronizes cs, sclk and mosi into the clk domain and detects sclk edges.
//   clk, rst_n           : system clock, synchronous active-low reset
//   cs, sclk, mosi       : raw pins
//   cs_s, mosi_s         : synchronized levels
//   sclk_rise, sclk_fall : single-clk strobes, one clk after the synced level moves
module spi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cs,
  input  logic sclk,
  input  logic mosi,
  output logic cs_s,
  output logic mosi_s,
  output logic sclk_rise,
  output logic sclk_fall
);

  logic [SYNC_STAGES-1:0] cs_q, sclk_q, mosi_q;
  logic                   sclk_d;

  // Chains clear to 0 so a low cs held through reset never looks like a
  // fresh cs assertion; the FSM waits for a synced high first.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cs_q   <= '0;
      sclk_q <= '0;
      mosi_q <= '0;
      sclk_d <= 1'b0;
    end else begin
      cs_q   <= {cs_q[SYNC_STAGES-2:0],   cs};
      sclk_q <= {sclk_q[SYNC_STAGES-2:0], sclk};
      mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
      sclk_d <= sclk_q[SYNC_STAGES-1];
    end
  end

  assign cs_s      = cs_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_q[SYNC_STAGES-1];
  assign sclk_rise =  sclk_q[SYNC_STAGES-1] & ~sclk_d;
  assign sclk_fall = ~sclk_q[SYNC_STAGES-1] &  sclk_d;

endmodule

// File: rtl/spi_mem_slave.sv
// SPI mode-0 slave fronting a DEPTH x DATA_W register memory.
// Frame: 3-bit instr, 5-bit addr (MSB first), then data bytes.
//   clk, rst_n : system clock, synchronous active-low reset
//   cs         : chip select, active-low
//   sclk, mosi : serial clock / data from master
//   miso       : serial data to master, 0 outside the read data phase
//   busy       : frame active (state != IDLE)
//   err_pulse  : one-clk pulse on an invalid opcode
module spi_mem_slave #(
  parameter int DEPTH       = 32,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cs,
  input  logic sclk,
  input  logic mosi,
  output logic miso,
  output logic busy,
  output logic err_pulse
);
  import spi_mem_pkg::*;

  logic cs_s, mosi_s, sclk_rise, sclk_fall;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .cs        (cs),
    .sclk      (sclk),
    .mosi      (mosi),
    .cs_s      (cs_s),
    .mosi_s    (mosi_s),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall)
  );

  logic [DEPTH-1:0][DATA_W-1:0] mem;
  state_e                       state;
  logic [2:0]                   instr;
  logic [ADDR_W-1:0]            addr;
  logic [DATA_W-1:0]            shift, rd_shift;
  logic [3:0]                   bit_cnt;
  logic                         at_end;   // burst has passed MAX_ADDR
  logic                         armed;    // synced cs seen high since reset

  logic [DATA_W-1:0] in_byte;
  logic [DATA_W-1:0] nxt_rd;
  logic [ADDR_W-1:0] nxt_addr;

  assign in_byte  = {shift[DATA_W-2:0], mosi_s};
  assign nxt_addr = addr + 1'b1;
  // Past the top address a burst read returns zeros instead of wrapping.
  assign nxt_rd   = (at_end || addr == MAX_ADDR) ? '0 : mem[nxt_addr];
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem       <= '0;
      state     <= IDLE;
      instr     <= '0;
      addr      <= '0;
      shift     <= '0;
      rd_shift  <= '0;
      bit_cnt   <= '0;
      at_end    <= 1'b0;
      armed     <= 1'b0;
      miso      <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= 1'b0;
      if (cs_s) armed <= 1'b1;

      // cs release beats any sclk edge in the same clk; partial byte dropped.
      if (state != IDLE && cs_s) begin
        state   <= IDLE;
        miso    <= 1'b0;
        bit_cnt <= '0;
        shift   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (armed && !cs_s) begin
              state   <= HDR;
              bit_cnt <= '0;
              shift   <= '0;
              at_end  <= 1'b0;
            end
          end

          HDR: begin
            if (sclk_rise) begin
              if (bit_cnt == 4'd7) begin
                instr   <= in_byte[7:5];
                addr    <= in_byte[4:0];
                bit_cnt <= '0;
                case (in_byte[7:5])
                  INS_WR, INS_BWR: state <= WR;
                  INS_RD, INS_BRD: begin
                    state    <= RD;
                    rd_shift <= mem[in_byte[4:0]];
                  end
                  default: begin
                    state     <= IGNORE;
                    err_pulse <= 1'b1;
                  end
                endcase
              end else begin
                shift   <= in_byte;
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end

          WR: begin
            if (sclk_rise) begin
              if (bit_cnt == 4'd7) begin
                bit_cnt <= '0;
                if (!at_end) mem[addr] <= in_byte;
                if (instr == INS_WR)       state  <= IGNORE;
                else if (addr == MAX_ADDR) at_end <= 1'b1;
                else                       addr   <= nxt_addr;
              end else begin
                shift   <= in_byte;
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end

          // Fall 0 is the header's last fall and presents the MSB; falls
          // 1..7 present the remaining bits; fall 8 closes the byte and, in a
          // burst, already presents the next byte's MSB.
          RD: begin
            if (sclk_fall) begin
              if (bit_cnt == 4'd8) begin
                if (instr == INS_RD) begin
                  state <= IGNORE;
                  miso  <= 1'b0;
                end else begin
                  if (addr == MAX_ADDR) at_end <= 1'b1;
                  else                  addr   <= nxt_addr;
                  miso     <= nxt_rd[DATA_W-1];
                  rd_shift <= {nxt_rd[DATA_W-2:0], 1'b0};
                  bit_cnt  <= 4'd1;
                end
              end else begin
                miso     <= rd_shift[DATA_W-1];
                rd_shift <= {rd_shift[DATA_W-2:0], 1'b0};
                bit_cnt  <= bit_cnt + 4'd1;
              end
            end
          end

          IGNORE: miso <= 1'b0;

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_mem_slave.sv
module tb_spi_mem_slave;
  import spi_mem_pkg::*;

  localparam int HALF = 6;  // sclk half period in clk cycles

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cs = 1'b1;
  logic sclk = 1'b0;
  logic mosi = 1'b0;
  logic miso, busy, err_pulse;

  int errs = 0;
  int checks = 0;
  int err_cnt = 0;

  spi_mem_slave dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cs        (cs),
    .sclk      (sclk),
    .mosi      (mosi),
    .miso      (miso),
    .busy      (busy),
    .err_pulse (err_pulse)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (err_pulse) err_cnt <= err_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic xfer(input logic [7:0] tx, input int nb, output logic [7:0] rx);
    rx = '0;
    for (int i = 7; i > 7 - nb; i--) begin
      mosi = tx[i];
      tick(HALF);
      sclk = 1'b1;
      rx[i] = miso;
      tick(HALF);
      sclk = 1'b0;
    end
  endtask

  task automatic cs_lo();
    cs = 1'b0;
    tick(HALF);
  endtask

  task automatic cs_hi();
    tick(HALF);
    cs = 1'b1;
    tick(8);
  endtask

  function automatic int nz_bytes();
    int n = 0;
    for (int i = 0; i < 32; i++) if (dut.mem[i] != 8'h00) n++;
    return n;
  endfunction

  logic [7:0] rx;

  initial begin
    tick(3);
    rst_n = 1'b1;
    tick(4);
    chk("rst_busy", busy, 0);
    chk("rst_miso", miso, 0);
    chk("rst_err", err_pulse, 0);
    chk("rst_mem", nz_bytes(), 0);

    // single write then single read at 0x01
    cs_lo(); xfer(8'h21, 8, rx); xfer(8'h01, 8, rx); cs_hi();
    cs_lo(); xfer(8'h41, 8, rx); chk("rd_hdr_miso", rx, 8'h00);
    xfer(8'h00, 8, rx); chk("rd_0x01", rx, 8'h01); cs_hi();
    chk("no_err_t1", err_cnt, 0);

    // burst write 0x10..0x13, burst read back
    cs_lo(); xfer(8'h70, 8, rx);
    xfer(8'hA1, 8, rx); xfer(8'hB2, 8, rx); xfer(8'hC3, 8, rx); xfer(8'hD4, 8, rx);
    cs_hi();
    cs_lo(); xfer(8'h90, 8, rx);
    xfer(8'h00, 8, rx); chk("brd_0", rx, 8'hA1);
    xfer(8'h00, 8, rx); chk("brd_1", rx, 8'hB2);
    xfer(8'h00, 8, rx); chk("brd_2", rx, 8'hC3);
    xfer(8'h00, 8, rx); chk("brd_3", rx, 8'hD4);
    cs_hi();
    cs_lo(); xfer(8'h54, 8, rx); xfer(8'h00, 8, rx); chk("rd_0x14", rx, 8'h00); cs_hi();

    // top-of-memory boundary, no wrap
    cs_lo(); xfer(8'h7E, 8, rx);
    xfer(8'h11, 8, rx); xfer(8'h22, 8, rx); xfer(8'h33, 8, rx);
    cs_hi();
    chk("nowrap_mem0", dut.mem[0], 8'h00);
    cs_lo(); xfer(8'h9E, 8, rx);
    xfer(8'h00, 8, rx); chk("bnd_1e", rx, 8'h11);
    xfer(8'h00, 8, rx); chk("bnd_1f", rx, 8'h22);
    xfer(8'h00, 8, rx); chk("bnd_past", rx, 8'h00);
    cs_hi();

    // invalid opcode 111, addr 5
    cs_lo(); xfer(8'hE5, 8, rx); xfer(8'hFF, 8, rx);
    chk("inv_miso", rx, 8'h00);
    chk("inv_state", dut.state, IGNORE);
    chk("inv_busy", busy, 1);
    cs_hi();
    chk("inv_err_cnt", err_cnt, 1);
    chk("inv_mem5", dut.mem[5], 8'h00);
    cs_lo(); xfer(8'h25, 8, rx); xfer(8'h3C, 8, rx); cs_hi();
    cs_lo(); xfer(8'h45, 8, rx); xfer(8'h00, 8, rx); chk("after_inv_rd", rx, 8'h3C); cs_hi();

    // partial data byte aborted by cs
    cs_lo(); xfer(8'h23, 8, rx); xfer(8'hFF, 4, rx);
    chk("part_busy_hi", busy, 1);
    cs = 1'b1;
    tick(4);
    chk("part_busy_lo", busy, 0);
    tick(4);
    chk("part_mem3", dut.mem[3], 8'h00);

    // reset mid burst write
    cs_lo(); xfer(8'h70, 8, rx); xfer(8'h55, 8, rx);
    rst_n = 1'b0; tick(1); rst_n = 1'b1; tick(1);
    chk("mrst_mem", nz_bytes(), 0);
    chk("mrst_miso", miso, 0);
    chk("mrst_busy", busy, 0);
    xfer(8'h21, 8, rx); xfer(8'h77, 8, rx);
    chk("mrst_nowr", nz_bytes(), 0);
    chk("mrst_idle", busy, 0);
    cs_hi();
    cs_lo(); xfer(8'h21, 8, rx); xfer(8'h5A, 8, rx); cs_hi();
    cs_lo(); xfer(8'h41, 8, rx); xfer(8'h00, 8, rx); chk("mrst_resume", rx, 8'h5A); cs_hi();
    chk("final_err_cnt", err_cnt, 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
